// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Sequential signed multiply / divide engine. Works on operand
//             magnitudes one bit per clock (shift-add multiply, restoring
//             divide), then applies the signs once in a fix-up cycle.
//             Results are presented on hi/lo with a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,          // asynchronous, active low
  input  logic             Start_mult_div,
  input  logic             op,             // 0 = MULT, 1 = DIV
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_div_done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_FIX     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  // mag_q is the adder operand: |a| for MULT, |b| for DIV.
  logic [WIDTH-1:0]   mag_q, mag_d;
  // acc_q low half starts as the shifting operand: |b| for MULT, |a| for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg, rem_neg, lo_neg;

  assign a_mag    = a[WIDTH-1] ? ('0 - a) : a;
  assign b_mag    = b[WIDTH-1] ? ('0 - b) : b;
  // MULT step: optional add of the multiplicand into the upper half, with carry.
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  // DIV step: remainder after the left shift needs WIDTH+1 bits to compare.
  assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem[WIDTH-1:0] - mag_q;
  assign prod_neg = '0 - acc_q;
  assign quo_neg  = '0 - acc_q[WIDTH-1:0];
  assign rem_neg  = '0 - acc_q[2*WIDTH-1:WIDTH];
  assign lo_neg   = '0 - acc_q[WIDTH-1:0];

  // Next-state and datapath update for the accept / iterate / fix-up sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (Start_mult_div) begin
          op_d    = op;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          mag_d   = op ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
          cnt_d   = '0;
          state_d = (op && (b == '0)) ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (!Start_mult_div) begin
          state_d = S_IDLE;
        end else begin
          if (!op_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else if (div_rem >= {1'b0, mag_q}) begin
            acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!Start_mult_div) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_DONE;
          div_zero_d = 1'b0;
          if (!op_q) begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
          end else if (mag_q == '0) begin
            // Divide by zero: the dividend magnitude is still in the low half.
            hi_d       = sa_q ? lo_neg : acc_q[WIDTH-1:0];
            lo_d       = {WIDTH{1'b1}};
            div_zero_d = 1'b1;
          end else begin
            lo_d = (sa_q ^ sb_q) ? quo_neg : acc_q[WIDTH-1:0];
            hi_d = sa_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!Start_mult_div) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi            = hi_q;
  assign lo            = lo_q;
  assign div_zero      = div_zero_q;
  assign mult_div_done = (state_q == S_DONE);
  assign busy          = (state_q == S_RUN) || (state_q == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Directed self-checking bench for mult_div_unit with
//             hand-computed expected results and handshake timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        busy;
  logic        div_zero;

  int checks;
  int errors;
  int done_cycle;
  int first_busy;
  int last_busy;
  logic [31:0] hold_hi;
  logic [31:0] hold_lo;
  logic        saw_done;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .Start_mult_div (start),
    .op             (op),
    .a              (a),
    .b              (b),
    .hi             (hi),
    .lo             (lo),
    .mult_div_done  (done),
    .busy           (busy),
    .div_zero       (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one operation in an idle cycle (cycle 0) and watch for done.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    op = o; a = x; b = y; start = 1'b1;
    done_cycle = -1;
    first_busy = -1;
    last_busy  = -1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (busy) begin
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
      if (done) begin
        done_cycle = k;
        break;
      end
    end
    // Scramble inputs: they must be ignored outside IDLE.
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ~o;
  endtask

  // Drop start for one cycle so the unit returns to IDLE.
  task automatic release_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi",   hi,   32'h0);
    check("reset_lo",   lo,   32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_dz",   {31'h0, div_zero}, 32'h0);
    rst_n = 1'b1;

    // 1: MULT 7 * -3
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul1_cycle", done_cycle, 32'd34);
    check("mul1_hi", hi, 32'hFFFF_FFFF);
    check("mul1_lo", lo, 32'hFFFF_FFEB);
    check("mul1_busy_first", first_busy, 32'd1);
    check("mul1_busy_last",  last_busy,  32'd33);
    release_start();

    // 2: signed division, truncation toward zero
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div1_cycle", done_cycle, 32'd34);
    check("div1_lo", lo, 32'hFFFF_FFFD);
    check("div1_hi", hi, 32'hFFFF_FFFF);
    release_start();
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'd1);
    check("div2_dz", {31'h0, div_zero}, 32'h0);
    release_start();
    do_op(1'b1, 32'd100, 32'd7);
    check("div3_lo", lo, 32'd14);
    check("div3_hi", hi, 32'd2);
    release_start();

    // 3: divide by zero, then a MULT clears the flag
    do_op(1'b1, 32'd5, 32'd0);
    check("dz_cycle", done_cycle, 32'd2);
    check("dz_flag", {31'h0, div_zero}, 32'h1);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    release_start();
    do_op(1'b1, 32'hFFFF_FFF6, 32'd0);
    check("dzneg_hi", hi, 32'hFFFF_FFF6);
    check("dzneg_flag", {31'h0, div_zero}, 32'h1);
    release_start();
    do_op(1'b0, 32'd12345, 32'd1000);
    check("dzclr_flag", {31'h0, div_zero}, 32'h0);
    check("mul2_hi", hi, 32'h0);
    check("mul2_lo", lo, 32'd12345000);
    release_start();

    // 4: most-negative operand edge cases
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    check("mulmin_hi", hi, 32'h4000_0000);
    check("mulmin_lo", lo, 32'h0);
    release_start();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0);
    check("divmin_dz", {31'h0, div_zero}, 32'h0);
    release_start();
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulm1_hi", hi, 32'h0);
    check("mulm1_lo", lo, 32'h1);

    // 5: start held high after done must not relaunch
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("hold_no_relaunch", {31'h0, saw_done}, 32'h0);
    release_start();
    do_op(1'b0, 32'd6, 32'd9);
    check("relaunch_cycle", done_cycle, 32'd34);
    check("relaunch_lo", lo, 32'd54);
    release_start();

    // 6a: abort in cycle 10
    hold_hi = hi; hold_lo = lo;
    @(posedge clk);
    #1;
    op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_c10", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("abort_busy_c11", {31'h0, busy}, 32'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'h0, saw_done}, 32'h0);
    check("abort_hi", hi, hold_hi);
    check("abort_lo", lo, hold_lo);

    // 6b: asynchronous reset mid-RUN clears everything at once
    do_op(1'b1, 32'd9, 32'd0);
    check("pre_rst_dz", {31'h0, div_zero}, 32'h1);
    release_start();
    @(posedge clk);
    #1;
    op = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi",   hi, 32'h0);
    check("arst_lo",   lo, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_done", {31'h0, done}, 32'h0);
    check("arst_dz",   {31'h0, div_zero}, 32'h0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(1'b0, 32'd11, 32'd13);
    check("post_rst_cycle", done_cycle, 32'd34);
    check("post_rst_lo", lo, 32'd143);
    release_start();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
